cnn_weight_loader: RTL

Streaming parameter writer for the convolution filter layers. It accepts a serial stream of signed filter coefficients and biases over a valid/ready handshake and builds a shadow register bank. Once a complete, correctly framed set has arrived, it commits the set atomically to an active bank. The active bank drives the flattened weight and bias buses of a filter layer, so that layer always sees a stable and complete parameter set.

---
 rtl/cnn_pkg.sv | 38 +++
 rtl/cnn_weight_bank.sv | 70 +++++++
 rtl/cnn_weight_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared loader state encoding and filter-layer sizing helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    function automatic int blk_words(input int fn);
        return fn * fn + 1;
    endfunction

    function automatic int frame_words(input int n1, input int n2, input int fn);
        return n1 * n2 * blk_words(fn);
    endfunction

    function automatic int w_flat_bits(input int width, input int n1, input int n2, input int fn);
        return n2 * n1 * fn * fn * width;
    endfunction

    function automatic int b_flat_bits(input int width, input int n1, input int n2);
        return n2 * n1 * width;
    endfunction

    // Index width that stays legal even for a single-entry range.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_weight_bank.sv
`default_nettype none
// ============================================================================
// Module      : cnn_weight_bank
// Description : Shadow/active double buffer for filter weights and biases.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_weight_bank
    import cnn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N1    = 2,
    parameter int N2    = 2,
    parameter int FN    = 3
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic                                    wr_en,
    input  logic [idx_bits(N2*N1*FN*FN)-1:0]        wr_idx,
    input  logic                                    wr_bias,
    input  logic [WIDTH-1:0]                        wr_data,
    input  logic                                    commit,
    output logic [w_flat_bits(WIDTH,N1,N2,FN)-1:0]  w_flat,
    output logic [b_flat_bits(WIDTH,N1,N2)-1:0]     b_flat
);

    localparam int NW  = N2 * N1 * FN * FN;
    localparam int NB  = N2 * N1;
    localparam int BIW = idx_bits(NB);

    logic [NW-1:0][WIDTH-1:0] sh_w_q, sh_w_d, act_w_q, act_w_d;
    logic [NB-1:0][WIDTH-1:0] sh_b_q, sh_b_d, act_b_q, act_b_d;

    always_comb begin
        sh_w_d  = sh_w_q;
        sh_b_d  = sh_b_q;
        act_w_d = act_w_q;
        act_b_d = act_b_q;
        if (wr_en) begin
            if (wr_bias) begin
                sh_b_d[wr_idx[BIW-1:0]] = wr_data;
            end else begin
                sh_w_d[wr_idx] = wr_data;
            end
        end
        // Commit copies the whole shadow so the layer never sees a partial set.
        if (commit) begin
            act_w_d = sh_w_q;
            act_b_d = sh_b_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sh_w_q  <= '0;
            sh_b_q  <= '0;
            act_w_q <= '0;
            act_b_q <= '0;
        end else begin
            sh_w_q  <= sh_w_d;
            sh_b_q  <= sh_b_d;
            act_w_q <= act_w_d;
            act_b_q <= act_b_d;
        end
    end

    assign w_flat = act_w_q;
    assign b_flat = act_b_q;

endmodule
`default_nettype wire

// File: rtl/cnn_weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : cnn_weight_loader
// Description : Framed stream loader that atomically commits filter parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_weight_loader
    import cnn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N1    = 2,
    parameter int N2    = 2,
    parameter int FN    = 3
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic                                    start,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    input  logic [WIDTH-1:0]                        s_data,
    input  logic                                    s_last,
    output logic [w_flat_bits(WIDTH,N1,N2,FN)-1:0]  w_flat,
    output logic [b_flat_bits(WIDTH,N1,N2)-1:0]     b_flat,
    output logic                                    weights_valid,
    output logic                                    done,
    output logic                                    busy,
    output logic                                    err
);

    localparam int FF   = FN * FN;
    localparam int NB   = N2 * N1;
    localparam int OFFW = idx_bits(blk_words(FN));
    localparam int BLKW = idx_bits(NB);
    localparam int IDXW = idx_bits(NB * FF);

    state_t          state_q, state_d;
    logic [OFFW-1:0] off_q, off_d;
    logic [BLKW-1:0] blk_q, blk_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            wv_q, wv_d;

    logic            accept;
    logic            is_bias;
    logic            last_word;
    logic [IDXW-1:0] wr_idx;

    assign s_ready   = (state_q == LOAD) || (state_q == DRAIN);
    assign busy      = (state_q != IDLE);
    assign accept    = s_valid && s_ready;
    assign is_bias   = (off_q == OFFW'(FF));
    assign last_word = is_bias && (blk_q == BLKW'(NB - 1));
    assign wr_idx    = is_bias ? IDXW'(blk_q)
                               : IDXW'(blk_q) * IDXW'(FF) + IDXW'(off_q);

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        blk_d   = blk_q;
        err_d   = err_q;
        done_d  = 1'b0;
        wv_d    = wv_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    off_d   = '0;
                    blk_d   = '0;
                    err_d   = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (is_bias) begin
                        off_d = '0;
                        blk_d = last_word ? '0 : blk_q + 1'b1;
                    end else begin
                        off_d = off_q + 1'b1;
                    end
                    if (last_word) begin
                        if (s_last) begin
                            state_d = COMMIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = DRAIN;
                        end
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (accept && s_last) begin
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                done_d  = 1'b1;
                wv_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            off_q   <= '0;
            blk_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            wv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            blk_q   <= blk_d;
            err_q   <= err_d;
            done_q  <= done_d;
            wv_q    <= wv_d;
        end
    end

    assign err           = err_q;
    assign done          = done_q;
    assign weights_valid = wv_q;

    cnn_weight_bank #(
        .WIDTH (WIDTH),
        .N1    (N1),
        .N2    (N2),
        .FN    (FN)
    ) u_bank (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   ((state_q == LOAD) && accept),
        .wr_idx  (wr_idx),
        .wr_bias (is_bias),
        .wr_data (s_data),
        .commit  (state_q == COMMIT),
        .w_flat  (w_flat),
        .b_flat  (b_flat)
    );

endmodule
`default_nettype wire
